// File: rtl/adc_acq_sequencer.sv
// Single-shot ADC acquisition sequencer: launches a programmed number of DMA frames
// with an idle gap between them and a per-frame watchdog.
module adc_acq_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [CNT_W-1:0] frame_gap,
    input  logic [CNT_W-1:0] timeout,
    input  logic             ready,
    input  logic             last,
    output logic             trig_next,
    output logic             seq_busy,
    output logic [CNT_W-1:0] frame_count,
    output logic             done,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, ARM, ACQ, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_frames_q, num_frames_d;
    logic [CNT_W-1:0] frame_gap_q, frame_gap_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] watchdog_q, watchdog_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic             trig_next_q, trig_next_d;
    logic             seq_busy_q, seq_busy_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            num_frames_q  <= '0;
            frame_gap_q   <= '0;
            timeout_q     <= '0;
            watchdog_q    <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
            trig_next_q   <= 1'b0;
            seq_busy_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_frames_q  <= num_frames_d;
            frame_gap_q   <= frame_gap_d;
            timeout_q     <= timeout_d;
            watchdog_q    <= watchdog_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
            trig_next_q   <= trig_next_d;
            seq_busy_q    <= seq_busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        num_frames_d  = num_frames_q;
        frame_gap_d   = frame_gap_q;
        timeout_d     = timeout_q;
        watchdog_d    = watchdog_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        trig_next_d   = 1'b0;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    num_frames_d  = num_frames;
                    frame_gap_d   = frame_gap;
                    timeout_d     = timeout;
                    frame_count_d = '0;
                    timeout_err_d = 1'b0;
                    state_d       = (num_frames == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (ready) begin
                    trig_next_d = 1'b1;
                    watchdog_d  = '0;
                    state_d     = ACQ;
                end
            end
            ACQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (watchdog_q != '1) watchdog_d = watchdog_q + CNT_W'(1);
                    // last takes priority over a coincident watchdog expiry
                    if (last) begin
                        frame_count_d = frame_count_q + CNT_W'(1);
                        if (frame_count_d == num_frames_q) begin
                            state_d = DONE;
                        end else if (frame_gap_q == '0) begin
                            state_d = ARM;
                        end else begin
                            gap_cnt_d = frame_gap_q;
                            state_d   = GAP;
                        end
                    end else if (timeout_q != '0 && watchdog_q == timeout_q - CNT_W'(1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q <= CNT_W'(1)) begin
                    state_d = ARM;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = !abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        seq_busy_d = (state_d != IDLE);
    end

    assign trig_next   = trig_next_q;
    assign seq_busy    = seq_busy_q;
    assign frame_count = frame_count_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
